// File: rtl/reg_file_seq_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALU
// operation codes and the register-file / PC mux select values.
package reg_file_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_ADDI  = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_JAL   = 4'd8;
    localparam logic [3:0] OP_LMHW  = 4'd9;
    localparam logic [3:0] OP_GETSP = 4'd10;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_PASS = 3'd4;

    localparam logic [2:0] RA_RS = 3'd0;
    localparam logic [2:0] RA_R1 = 3'd1;
    localparam logic [2:0] RA_R0 = 3'd2;
    localparam logic [2:0] RA_R6 = 3'd3;
    localparam logic [2:0] RA_R7 = 3'd4;

    localparam logic [1:0] WS_RS = 2'd0;
    localparam logic [1:0] WS_R1 = 2'd1;
    localparam logic [1:0] WS_R0 = 2'd2;

    localparam logic [1:0] DST_ALU = 2'd0;
    localparam logic [1:0] DST_MEM = 2'd1;
    localparam logic [1:0] DST_SP  = 2'd2;
    localparam logic [1:0] DST_PC1 = 2'd3;

    localparam logic [1:0] PC_INC   = 2'd0;
    localparam logic [1:0] PC_READB = 2'd1;
    localparam logic [1:0] PC_READA = 2'd2;

    // Opcodes 11..14 are unassigned and execute as a PC+1 NOP.
    function automatic logic isLegalOp(input logic [3:0] op);
        return (op <= OP_GETSP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/reg_file_seq_ctrl_if.sv
// Memory bus between the control FSM (master) and instruction/data memory (slave).
interface reg_file_seq_ctrl_if;

    logic [15:0] MemData;
    logic        MemReady;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;

    modport master (
        input  MemData,
        input  MemReady,
        output MemRead,
        output MemWrite,
        output IorD
    );

    modport slave (
        output MemData,
        output MemReady,
        input  MemRead,
        input  MemWrite,
        input  IorD
    );

endinterface

// File: rtl/reg_file_seq_decode.sv
// Combinational output decode: maps the FSM state, the held opcode and the
// ALU zero flag onto every datapath control of the core.
module reg_file_seq_decode
    import reg_file_seq_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       aluZero,
    input  logic       memReady,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic [2:0] aluOp,
    output logic       aluSrcB,
    output logic       regWrite,
    output logic [2:0] regASrc,
    output logic       beq,
    output logic [1:0] regWriteSrc,
    output logic [1:0] regDst,
    output logic       lmhw,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       halted,
    output logic       illegalOp
);

    always_comb begin
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        aluOp       = ALU_ADD;
        aluSrcB     = 1'b0;
        regWrite    = 1'b0;
        regASrc     = RA_RS;
        beq         = 1'b0;
        regWriteSrc = WS_RS;
        regDst      = DST_ALU;
        lmhw        = 1'b0;
        pcWrite     = 1'b0;
        pcSrc       = PC_INC;
        halted      = 1'b0;
        illegalOp   = 1'b0;

        case (state)
            FETCH: begin
                memRead = 1'b1;
            end

            DECODE: begin
                illegalOp = !isLegalOp(op);
            end

            EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        aluOp = {1'b0, op[1:0]};
                    end
                    OP_ADDI, OP_LW: begin
                        aluSrcB = 1'b1;
                    end
                    OP_SW: begin
                        regASrc = RA_R6;
                        aluSrcB = 1'b1;
                    end
                    OP_LMHW: begin
                        regASrc = RA_R7;
                        aluSrcB = 1'b1;
                    end
                    OP_BEQ: begin
                        regASrc = RA_R1;
                        beq     = 1'b1;
                        aluOp   = ALU_PASS;
                        pcWrite = 1'b1;
                        pcSrc   = aluZero ? PC_READB : PC_INC;
                    end
                    OP_JAL: begin
                        regASrc     = RA_RS;
                        regWrite    = 1'b1;
                        regWriteSrc = WS_R0;
                        regDst      = DST_PC1;
                        pcWrite     = 1'b1;
                        pcSrc       = PC_READA;
                    end
                    OP_GETSP: begin
                        regWrite    = 1'b1;
                        regWriteSrc = WS_RS;
                        regDst      = DST_SP;
                        pcWrite     = 1'b1;
                        pcSrc       = PC_INC;
                    end
                    default: begin
                        pcWrite = 1'b1;
                        pcSrc   = PC_INC;
                    end
                endcase
            end

            MEM: begin
                iorD = 1'b1;
                // A store retires here, so PC may only advance on the completing cycle.
                if (op == OP_SW) begin
                    memWrite = 1'b1;
                    pcWrite  = memReady;
                    pcSrc    = PC_INC;
                end else begin
                    memRead = 1'b1;
                end
            end

            WB: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                pcSrc    = PC_INC;
                case (op)
                    OP_LW: begin
                        regDst      = DST_MEM;
                        regWriteSrc = WS_R1;
                    end
                    OP_LMHW: begin
                        regDst      = DST_MEM;
                        regWriteSrc = WS_RS;
                        lmhw        = 1'b1;
                    end
                    default: begin
                        regDst      = DST_ALU;
                        regWriteSrc = WS_RS;
                    end
                endcase
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: rtl/reg_file_seq_ctrl.sv
// Multicycle control FSM for the 16-bit, 8-register core: fetch, decode,
// execute, memory and write-back sequencing with a bounded memory wait.
module reg_file_seq_ctrl
    import reg_file_seq_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    reg_file_seq_ctrl_if.master        bus,
    input  logic                       ALUZero,
    output logic [2:0]                 rs,
    output logic [2:0]                 rt,
    output logic [2:0]                 ALUOp,
    output logic                       ALUSrcB,
    output logic                       RegWrite,
    output logic [2:0]                 RegASrc,
    output logic                       BEQ,
    output logic [1:0]                 RegWriteSrc,
    output logic [1:0]                 RegDst,
    output logic                       lmhw,
    output logic                       PCWrite,
    output logic [1:0]                 PCSrc,
    output logic                       Halted,
    output logic                       BusError,
    output logic                       IllegalOp
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            nextState;
    logic [15:0]       ir;
    logic [3:0]        op;
    logic [WAIT_W-1:0] waitCnt;
    logic              busError;
    logic              irWrite;
    logic              timeout;
    logic              unusedIrBits;

    assign op = ir[15:12];
    assign rs = ir[11:9];
    assign rt = ir[8:6];
    assign BusError = busError;

    // The low six instruction bits carry no control information for this FSM.
    assign unusedIrBits = ^ir[5:0];

    always_comb begin
        nextState = state;
        irWrite   = 1'b0;
        timeout   = 1'b0;

        case (state)
            FETCH: begin
                if (bus.MemReady) begin
                    irWrite   = 1'b1;
                    nextState = DECODE;
                end else if (waitCnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    nextState = FAULT;
                end
            end

            DECODE: begin
                nextState = (op == OP_HALT) ? HALT : EXEC;
            end

            EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: nextState = WB;
                    OP_LW, OP_SW, OP_LMHW:                  nextState = MEM;
                    default:                                nextState = FETCH;
                endcase
            end

            MEM: begin
                if (bus.MemReady) begin
                    nextState = (op == OP_SW) ? FETCH : WB;
                end else if (waitCnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    nextState = FAULT;
                end
            end

            WB:      nextState = FETCH;
            HALT:    nextState = HALT;
            FAULT:   nextState = FAULT;
            default: nextState = FETCH;
        endcase
    end

    // The wait counter restarts on every state change, so it only ever
    // measures stall cycles spent in the current FETCH or MEM visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            ir       <= '0;
            waitCnt  <= '0;
            busError <= 1'b0;
        end else begin
            state <= nextState;
            if (irWrite) begin
                ir <= bus.MemData;
            end
            if (timeout) begin
                busError <= 1'b1;
            end
            if (nextState != state) begin
                waitCnt <= '0;
            end else if ((state == FETCH || state == MEM) && !bus.MemReady) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end
        end
    end

    reg_file_seq_decode decode (
        .state       (state),
        .op          (op),
        .aluZero     (ALUZero),
        .memReady    (bus.MemReady),
        .memRead     (bus.MemRead),
        .memWrite    (bus.MemWrite),
        .iorD        (bus.IorD),
        .aluOp       (ALUOp),
        .aluSrcB     (ALUSrcB),
        .regWrite    (RegWrite),
        .regASrc     (RegASrc),
        .beq         (BEQ),
        .regWriteSrc (RegWriteSrc),
        .regDst      (RegDst),
        .lmhw        (lmhw),
        .pcWrite     (PCWrite),
        .pcSrc       (PCSrc),
        .halted      (Halted),
        .illegalOp   (IllegalOp)
    );

endmodule

// File: doc/reg_file_seq_ctrl.md
Name: reg_file_seq_ctrl

Overview:
Multicycle control FSM for the 16-bit, 8-register core. It fetches an instruction, holds it in an internal instruction register, and sequences the register-file input muxes, ALU, memory handshake and PC update for each opcode. Its outputs drive the register-file input mux selects (RegASrc, BEQ, RegWriteSrc, RegDst, lmhw), RegWrite, PC, ALU and memory controls.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for MemReady before BusError.
WAIT_W, 4, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
MemData  in  16  memory read data, captured as the instruction in FETCH
MemReady  in  1  memory completes the current access
ALUZero  in  1  ALU result is zero
rs  out  3  IR[11:9]
rt  out  3  IR[8:6]; doubles as the 3-bit immediate
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IorD  out  1  0 = PC address, 1 = ALUOut address
ALUOp  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS A
ALUSrcB  out  1  0 = ReadB data, 1 = sign-extended rt
RegWrite  out  1  register-file write enable
RegASrc  out  3  0 rs, 1 R1, 2 R0, 3 R6, 4 R7
BEQ  out  1  ReadB selects R2 or R3 by rt[2]
RegWriteSrc  out  2  0 rs, 1 R1, 2 R0
RegDst  out  2  0 ALUOut, 1 MemOut, 2 SPAddress, 3 PC+1
lmhw  out  1  byte-merge write with R5
PCWrite  out  1  PC load enable
PCSrc  out  2  0 PC+1, 1 ReadB data (branch target), 2 ReadA data
Halted  out  1  HALT state reached
BusError  out  1  sticky; set on MemReady timeout
IllegalOp  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: State=FETCH, IR=0, WaitCnt=0, BusError=0. Outputs are decoded from State and IR, so the only asserted output after reset is MemRead=1 (IorD=0). All other outputs are 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- Instruction encoding: op=IR[15:12].
  - 0–3: R-type ADD/SUB/AND/OR, rs = rs op rt.
  - 4: ADDI, rs = rs + imm.
  - 5: LW, R1 = M[rs+imm].
  - 6: SW, M[R6+imm] = rt.
  - 7: BEQ, if R1==0 then PC = R2 or R3.
  - 8: JAL, R0 = PC+1 and PC = rs.
  - 9: LMHW, rs = {R5[7:0], M[R7+imm][15:8]}.
  - 10: GETSP, rs = SPAddress.
  - 15: HALT.
  - Any other opcode is illegal.
- FETCH: MemRead=1, IorD=0. On MemReady, load IR from MemData, assert IRWrite internally, go to DECODE.
- DECODE: one cycle, no outputs asserted. An illegal opcode pulses IllegalOp and goes to EXEC as a NOP (PC+1 only). HALT goes to HALT.
- EXEC: drive RegASrc, ALUOp and ALUSrcB for the opcode.
  - R-type and ADDI go to WB.
  - LW, SW and LMHW go to MEM.
  - BEQ: RegASrc=1, BEQ=1, ALUOp=4. Assert PCWrite with PCSrc=1 if ALUZero, else PCSrc=0. Go to FETCH.
  - JAL: RegASrc=0, RegWrite=1, RegWriteSrc=2, RegDst=3, PCWrite=1, PCSrc=2. Go to FETCH.
  - GETSP: RegWrite=1, RegWriteSrc=0, RegDst=2, PCWrite=1, PCSrc=0. Go to FETCH.
- MEM: IorD=1. MemRead for LW/LMHW, MemWrite for SW. Hold until MemReady.
  - SW completes here: PCWrite=1, PCSrc=0, go to FETCH.
  - LW and LMHW go to WB.
- WB: RegWrite=1, PCWrite=1, PCSrc=0.
  - R-type/ADDI: RegDst=0, RegWriteSrc=0.
  - LW: RegDst=1, RegWriteSrc=1.
  - LMHW: RegDst=1, RegWriteSrc=0, lmhw=1.
  - Go to FETCH.
- PC stability: PC is written only in the final state of each instruction, so the PC+1 value seen by the register-file muxes is always the current instruction's PC+1.
- Cycle counts with zero-wait memory:
  - R-type, ADDI: 4.
  - LW, LMHW: 5.
  - SW: 4.
  - BEQ, JAL, GETSP: 3.
- Wait counter: WaitCnt clears on entry to FETCH/MEM and increments each cycle MemReady=0. When it reaches MEM_TIMEOUT with MemReady still low, go to FAULT and set BusError. MemReady arriving in that same cycle wins over the timeout.
- FAULT and HALT: all enables 0, Halted=1 in HALT only. Both states are exited only by reset.
- Outside FETCH/MEM: MemReady is ignored.
- Reset mid-instruction: returns to FETCH immediately. No partial RegWrite, MemWrite or PCWrite survives the reset.

Decomposition:
- Shared package: opcode constants, state encoding, ALUOp codes, and the mux select codes for RegASrc, RegWriteSrc, RegDst and PCSrc.
- Sub-module: one natural sub-module, reg_file_seq_decode. It is the combinational map from {State, op, ALUZero} to outputs.

Test Plan:
- Reset: rst_n low mid-EXEC -> next cycle MemRead=1, RegWrite=0, PCWrite=0, BusError=0.
- ADD: 0x0280 (rs=1, rt=2) with MemReady always 1 -> WB cycle 4 shows RegWrite=1, RegDst=0, RegWriteSrc=0, PCWrite=1, PCSrc=0.
- LW: MemReady delayed 3 cycles in MEM -> MemRead held 4 cycles; WB shows RegDst=1, RegWriteSrc=1; total 8 cycles.
- BEQ: 0x7100 (rt[2]=1) -> ALUZero=1 gives BEQ=1, PCSrc=1, PCWrite=1; ALUZero=0 gives PCSrc=0.
- LMHW plus an illegal opcode: LMHW 0x9400 -> WB shows lmhw=1. Opcode 0xC000 -> IllegalOp for 1 cycle, then PC+1.
- Timeout: MemReady stuck 0 in FETCH -> after 15 cycles, FAULT with BusError=1 and no further outputs; MemReady=1 on cycle 15 -> normal fetch.
